// File: rtl/reg_interconnect_rr.sv
// reg_interconnect_rr: N-port register-bus interconnect.
// Arbitrates NUM_PORTS write masters onto one memory write bus and
// NUM_PORTS read masters onto one memory read bus. The two channels run
// independent IDLE/BUSY/RELEASE arbiters, so one read and one write can
// be in flight at once. Arbitration is round-robin (ARB_MODE=0) or fixed
// priority with the lowest index winning (ARB_MODE=1). A transfer left
// unanswered for TIMEOUT_CYCLES in BUSY completes with an error flag.
module reg_interconnect_rr #(
  parameter int NUM_PORTS      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_DEPTH      = 256,
  parameter int ADDR_WIDTH     = $clog2(RAM_DEPTH),
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_PORTS-1:0]             w_s_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  w_s_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  w_s_data,
  output logic [NUM_PORTS-1:0]             w_s_ready,
  output logic [NUM_PORTS-1:0]             w_s_err,
  input  logic [NUM_PORTS-1:0]             r_s_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  r_s_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  r_s_data,
  output logic [NUM_PORTS-1:0]             r_s_ready,
  output logic [NUM_PORTS-1:0]             r_s_err,
  output logic                             w_mem_valid,
  output logic [ADDR_WIDTH-1:0]            w_mem_addr,
  output logic [DATA_WIDTH-1:0]            w_mem_data,
  input  logic                             w_mem_ready,
  output logic                             r_mem_valid,
  output logic [ADDR_WIDTH-1:0]            r_mem_addr,
  input  logic [DATA_WIDTH-1:0]            r_mem_data,
  input  logic                             r_mem_ready
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  // Pointer starts at the last port so the first round-robin scan begins at port 0.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  // Winner among requesters: scan upward from ptr+1 with wrap (round-robin)
  // or from index 0 (fixed priority).
  function automatic logic [IDX_W-1:0] arb_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [IDX_W-1:0]     ptr);
    logic             found;
    logic [IDX_W-1:0] win;
    int               idx;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (ARB_MODE == 1) idx = k - 1;
      else               idx = (int'(ptr) + k) % NUM_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
    return win;
  endfunction

  // ---------------------------------------------------------------- write channel
  state_e                 w_state, w_state_d;
  logic [IDX_W-1:0]       w_grant, w_grant_d, w_ptr, w_ptr_d, w_pick;
  logic [CNT_W-1:0]       w_cnt, w_cnt_d;
  logic                   w_mem_valid_d, w_timeout;
  logic [ADDR_WIDTH-1:0]  w_mem_addr_d;
  logic [DATA_WIDTH-1:0]  w_mem_data_d;
  logic [NUM_PORTS-1:0]   w_s_ready_d, w_s_err_d, w_onehot;

  assign w_pick    = arb_pick(w_s_valid, w_ptr);
  assign w_onehot  = NUM_PORTS'(1) << w_grant;
  assign w_timeout = TO_EN && (w_cnt == TO_LAST);

  // Write arbiter: next state and next values of every registered output.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave
    // one unassigned and infer a latch; combinational logic uses blocking '='.
    w_state_d     = w_state;
    w_grant_d     = w_grant;
    w_ptr_d       = w_ptr;
    w_cnt_d       = w_cnt;
    w_mem_valid_d = w_mem_valid;
    w_mem_addr_d  = w_mem_addr;
    w_mem_data_d  = w_mem_data;
    w_s_ready_d   = w_s_ready;
    w_s_err_d     = w_s_err;
    case (w_state)
      IDLE: begin
        if ((|w_s_valid) && !w_mem_ready) begin
          w_grant_d     = w_pick;
          w_mem_addr_d  = w_s_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          w_mem_data_d  = w_s_data[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
          w_mem_valid_d = 1'b1;
          w_cnt_d       = '0;
          w_state_d     = BUSY;
        end
      end
      BUSY: begin
        // A memory answer wins over a timeout landing in the same cycle.
        if (w_mem_ready || w_timeout) begin
          w_mem_valid_d = 1'b0;
          w_s_ready_d   = w_onehot;
          w_s_err_d     = w_mem_ready ? '0 : w_onehot;
          w_ptr_d       = w_grant;
          w_state_d     = RELEASE;
        end else begin
          w_cnt_d = w_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!w_s_valid[w_grant]) begin
          w_s_ready_d = '0;
          w_s_err_d   = '0;
          w_state_d   = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Write arbiter registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    if (!rstn) begin
      w_state     <= IDLE;
      w_grant     <= '0;
      w_ptr       <= PTR_RST;
      w_cnt       <= '0;
      w_mem_valid <= 1'b0;
      w_mem_addr  <= '0;
      w_mem_data  <= '0;
      w_s_ready   <= '0;
      w_s_err     <= '0;
    end else begin
      w_state     <= w_state_d;
      w_grant     <= w_grant_d;
      w_ptr       <= w_ptr_d;
      w_cnt       <= w_cnt_d;
      w_mem_valid <= w_mem_valid_d;
      w_mem_addr  <= w_mem_addr_d;
      w_mem_data  <= w_mem_data_d;
      w_s_ready   <= w_s_ready_d;
      w_s_err     <= w_s_err_d;
    end
  end

  // ----------------------------------------------------------------- read channel
  state_e                          r_state, r_state_d;
  logic [IDX_W-1:0]                r_grant, r_grant_d, r_ptr, r_ptr_d, r_pick;
  logic [CNT_W-1:0]                r_cnt, r_cnt_d;
  logic                            r_mem_valid_d, r_timeout;
  logic [ADDR_WIDTH-1:0]           r_mem_addr_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_s_data_d;
  logic [NUM_PORTS-1:0]            r_s_ready_d, r_s_err_d, r_onehot;

  assign r_pick    = arb_pick(r_s_valid, r_ptr);
  assign r_onehot  = NUM_PORTS'(1) << r_grant;
  assign r_timeout = TO_EN && (r_cnt == TO_LAST);

  // Read arbiter: same FSM as the write side, plus per-port data capture.
  always_comb begin
    r_state_d     = r_state;
    r_grant_d     = r_grant;
    r_ptr_d       = r_ptr;
    r_cnt_d       = r_cnt;
    r_mem_valid_d = r_mem_valid;
    r_mem_addr_d  = r_mem_addr;
    r_s_data_d    = r_s_data;
    r_s_ready_d   = r_s_ready;
    r_s_err_d     = r_s_err;
    case (r_state)
      IDLE: begin
        if ((|r_s_valid) && !r_mem_ready) begin
          r_grant_d     = r_pick;
          r_mem_addr_d  = r_s_addr[int'(r_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          r_mem_valid_d = 1'b1;
          r_cnt_d       = '0;
          r_state_d     = BUSY;
        end
      end
      BUSY: begin
        if (r_mem_ready || r_timeout) begin
          r_mem_valid_d = 1'b0;
          r_s_ready_d   = r_onehot;
          r_s_err_d     = r_mem_ready ? '0 : r_onehot;
          // A timed-out read returns zero rather than stale bus data.
          r_s_data_d[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH] = r_mem_ready ? r_mem_data : '0;
          r_ptr_d       = r_grant;
          r_state_d     = RELEASE;
        end else begin
          r_cnt_d = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!r_s_valid[r_grant]) begin
          r_s_ready_d = '0;
          r_s_err_d   = '0;
          r_state_d   = IDLE;
        end
      end
      default: r_state_d = IDLE;
    endcase
  end

  // Read arbiter registers, including the per-port read-data holding store.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_ptr       <= PTR_RST;
      r_cnt       <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      // NOTE: the read-data store drives r_s_data directly, so it is reset
      // like any other output instead of being left as unreset storage.
      r_s_data    <= '0;
      r_s_ready   <= '0;
      r_s_err     <= '0;
    end else begin
      r_state     <= r_state_d;
      r_grant     <= r_grant_d;
      r_ptr       <= r_ptr_d;
      r_cnt       <= r_cnt_d;
      r_mem_valid <= r_mem_valid_d;
      r_mem_addr  <= r_mem_addr_d;
      r_s_data    <= r_s_data_d;
      r_s_ready   <= r_s_ready_d;
      r_s_err     <= r_s_err_d;
    end
  end

endmodule

// File: tb/tb_reg_interconnect_rr.sv
// Directed bench for reg_interconnect_rr. Instance a runs round-robin,
// instance b fixed priority; both share inputs and use TIMEOUT_CYCLES=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_interconnect_rr;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk, rstn;
  logic [NP-1:0]    w_s_valid, r_s_valid;
  logic [NP*AW-1:0] w_s_addr, r_s_addr;
  logic [NP*DW-1:0] w_s_data;
  logic             w_mem_ready, r_mem_ready;
  logic [DW-1:0]    r_mem_data;

  logic [NP-1:0]    a_w_s_ready, a_w_s_err, a_r_s_ready, a_r_s_err;
  logic [NP*DW-1:0] a_r_s_data;
  logic             a_w_mem_valid, a_r_mem_valid;
  logic [AW-1:0]    a_w_mem_addr, a_r_mem_addr;
  logic [DW-1:0]    a_w_mem_data;

  logic [NP-1:0]    b_w_s_ready, b_w_s_err, b_r_s_ready, b_r_s_err;
  logic [NP*DW-1:0] b_r_s_data;
  logic             b_w_mem_valid, b_r_mem_valid;
  logic [AW-1:0]    b_w_mem_addr, b_r_mem_addr;
  logic [DW-1:0]    b_w_mem_data;

  int total, bad;

  reg_interconnect_rr #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .RAM_DEPTH(256),
                        .ARB_MODE(0), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rstn(rstn),
    .w_s_valid(w_s_valid), .w_s_addr(w_s_addr), .w_s_data(w_s_data),
    .w_s_ready(a_w_s_ready), .w_s_err(a_w_s_err),
    .r_s_valid(r_s_valid), .r_s_addr(r_s_addr), .r_s_data(a_r_s_data),
    .r_s_ready(a_r_s_ready), .r_s_err(a_r_s_err),
    .w_mem_valid(a_w_mem_valid), .w_mem_addr(a_w_mem_addr), .w_mem_data(a_w_mem_data),
    .w_mem_ready(w_mem_ready),
    .r_mem_valid(a_r_mem_valid), .r_mem_addr(a_r_mem_addr),
    .r_mem_data(r_mem_data), .r_mem_ready(r_mem_ready)
  );

  reg_interconnect_rr #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .RAM_DEPTH(256),
                        .ARB_MODE(1), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rstn(rstn),
    .w_s_valid(w_s_valid), .w_s_addr(w_s_addr), .w_s_data(w_s_data),
    .w_s_ready(b_w_s_ready), .w_s_err(b_w_s_err),
    .r_s_valid(r_s_valid), .r_s_addr(r_s_addr), .r_s_data(b_r_s_data),
    .r_s_ready(b_r_s_ready), .r_s_err(b_r_s_err),
    .w_mem_valid(b_w_mem_valid), .w_mem_addr(b_w_mem_addr), .w_mem_data(b_w_mem_data),
    .w_mem_ready(w_mem_ready),
    .r_mem_valid(b_r_mem_valid), .r_mem_addr(b_r_mem_addr),
    .r_mem_data(r_mem_data), .r_mem_ready(r_mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    w_s_valid = '0; w_s_addr = '0; w_s_data = '0; w_mem_ready = 1'b0;
    r_s_valid = '0; r_s_addr = '0; r_mem_data = '0; r_mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Full read on instance a: grant, memory answer after lat cycles, held
  // ready while valid stays high, then release with the data retained.
  task automatic do_read(input int p, input logic [7:0] addr, input logic [31:0] d,
                         input int lat);
    r_s_valid[p] = 1'b1;
    r_s_addr[p*AW +: AW] = addr;
    tick();
    check("rd_mem_valid", a_r_mem_valid, 1);
    check("rd_mem_addr", a_r_mem_addr, addr);
    repeat (lat - 1) tick();
    r_mem_ready = 1'b1;
    r_mem_data  = d;
    tick();
    r_mem_ready = 1'b0;
    r_mem_data  = '0;
    check("rd_ready", a_r_s_ready, 32'(1 << p));
    check("rd_data", a_r_s_data[p*DW +: DW], d);
    check("rd_err", a_r_s_err, 0);
    check("rd_mem_valid_drop", a_r_mem_valid, 0);
    tick();
    check("rd_ready_held", a_r_s_ready, 32'(1 << p));
    r_s_valid[p] = 1'b0;
    tick();
    check("rd_ready_clear", a_r_s_ready, 0);
    check("rd_data_kept", a_r_s_data[p*DW +: DW], d);
  endtask

  // Round-robin write service on instance a: check grant data, answer,
  // check ready, drop the served port for one cycle, re-raise, next grant.
  task automatic serve_w(input logic [31:0] exp_data, input logic [2:0] exp_ready);
    check("rr_mem_valid", a_w_mem_valid, 1);
    check("rr_mem_data", a_w_mem_data, exp_data);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    check("rr_ready", a_w_s_ready, exp_ready);
    w_s_valid = w_s_valid & ~exp_ready;
    tick();
    check("rr_ready_clear", a_w_s_ready, 0);
    w_s_valid = w_s_valid | exp_ready;
    tick();
  endtask

  initial begin
    int busy;
    int n;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    clear_inputs();

    // Reset state.
    tick();
    check("rst_w_ready", a_w_s_ready, 0);
    check("rst_w_err", a_w_s_err, 0);
    check("rst_r_ready", a_r_s_ready, 0);
    check("rst_r_err", a_r_s_err, 0);
    check("rst_w_mem_valid", a_w_mem_valid, 0);
    check("rst_w_mem_addr", a_w_mem_addr, 0);
    check("rst_w_mem_data", a_w_mem_data, 0);
    check("rst_r_mem_valid", a_r_mem_valid, 0);
    check("rst_r_mem_addr", a_r_mem_addr, 0);
    check("rst_r_data0", a_r_s_data[0 +: DW], 0);
    check("rst_b_w_mem_valid", b_w_mem_valid, 0);
    rstn = 1'b1;
    tick();

    // Port 0 reads 0x20, memory answers 0x10 after 3 cycles.
    do_read(0, 8'h20, 32'h10, 3);

    // Port 1 writes 0x77 to 0x0F and reads 0x0F at the same time.
    w_s_valid = 3'b010; w_s_addr[AW +: AW] = 8'h0F; w_s_data[DW +: DW] = 32'h77;
    r_s_valid = 3'b010; r_s_addr[AW +: AW] = 8'h0F;
    tick();
    check("both_w_valid", a_w_mem_valid, 1);
    check("both_r_valid", a_r_mem_valid, 1);
    check("both_w_addr", a_w_mem_addr, 8'h0F);
    check("both_w_data", a_w_mem_data, 32'h77);
    check("both_r_addr", a_r_mem_addr, 8'h0F);
    w_mem_ready = 1'b1; r_mem_ready = 1'b1; r_mem_data = 32'h77;
    tick();
    w_mem_ready = 1'b0; r_mem_ready = 1'b0; r_mem_data = '0;
    check("both_w_ready", a_w_s_ready, 3'b010);
    check("both_r_ready", a_r_s_ready, 3'b010);
    check("both_r_data1", a_r_s_data[DW +: DW], 32'h77);
    check("both_r_data0_kept", a_r_s_data[0 +: DW], 32'h10);
    check("both_w_err", a_w_s_err, 0);
    check("both_r_err", a_r_s_err, 0);
    w_s_valid = '0; r_s_valid = '0;
    tick();
    check("both_w_clear", a_w_s_ready, 0);
    check("both_r_clear", a_r_s_ready, 0);

    // Round-robin fairness: all three write ports request.
    do_reset();
    w_s_addr  = {8'h03, 8'h02, 8'h01};
    w_s_data  = {32'hA2, 32'hA1, 32'hA0};
    w_s_valid = 3'b111;
    tick();
    serve_w(32'hA0, 3'b001);
    serve_w(32'hA1, 3'b010);
    serve_w(32'hA2, 3'b100);
    check("rr_wrap_data", a_w_mem_data, 32'hA0);

    // Fixed priority: ports 0 and 2 request continuously, port 0 always wins.
    do_reset();
    w_s_data  = {32'hA2, 32'hA1, 32'hA0};
    w_s_valid = 3'b101;
    tick();
    check("fp_grant1", b_w_mem_data, 32'hA0);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    check("fp_ready1", b_w_s_ready, 3'b001);
    w_s_valid = 3'b100;
    tick();
    w_s_valid = 3'b101;
    tick();
    check("fp_grant2", b_w_mem_data, 32'hA0);
    check("rr_contrast", a_w_mem_data, 32'hA2);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    check("fp_ready2", b_w_s_ready, 3'b001);
    w_s_valid = 3'b100;
    tick();
    w_s_valid = 3'b101;
    tick();
    check("fp_grant3", b_w_mem_data, 32'hA0);

    // Timeout: normal read, unanswered read, then normal read again.
    do_reset();
    do_read(2, 8'h33, 32'h55, 2);
    r_s_valid[2] = 1'b1;
    r_s_addr[2*AW +: AW] = 8'h34;
    tick();
    busy = 0;
    n = 0;
    while (!a_r_s_ready[2] && n < 40) begin
      if (a_r_mem_valid) busy++;
      tick();
      n++;
    end
    check("to_busy_cycles", busy, 16);
    check("to_ready", a_r_s_ready, 3'b100);
    check("to_err", a_r_s_err, 3'b100);
    check("to_data_zero", a_r_s_data[2*DW +: DW], 0);
    check("to_mem_valid", a_r_mem_valid, 0);
    r_s_valid[2] = 1'b0;
    tick();
    check("to_err_clear", a_r_s_err, 0);
    do_read(2, 8'h35, 32'h66, 1);

    // Master drops valid one cycle after grant: write still completes.
    w_s_valid = 3'b001; w_s_addr[0 +: AW] = 8'h44; w_s_data[0 +: DW] = 32'h5A;
    tick();
    check("drop_grant", a_w_mem_valid, 1);
    w_s_valid = '0;
    tick();
    check("drop_busy_valid", a_w_mem_valid, 1);
    check("drop_busy_data", a_w_mem_data, 32'h5A);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    check("drop_ready", a_w_s_ready, 3'b001);
    tick();
    check("drop_pulse_1cyc", a_w_s_ready, 0);
    w_s_valid = 3'b010; w_s_data[DW +: DW] = 32'h5B;
    tick();
    check("drop_idle_grant", a_w_mem_data, 32'h5B);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    check("drop_next_ready", a_w_s_ready, 3'b010);
    w_s_valid = '0;
    tick();

    // Reset asserted during BUSY: outputs clear at once, no completion.
    w_s_valid = 3'b001; w_s_data[0 +: DW] = 32'h5C;
    tick();
    check("mid_busy", a_w_mem_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_mem_valid", a_w_mem_valid, 0);
    check("mid_rst_mem_data", a_w_mem_data, 0);
    check("mid_rst_r_data2", a_r_s_data[2*DW +: DW], 0);
    w_mem_ready = 1'b1;
    tick();
    tick();
    check("mid_rst_no_ready", a_w_s_ready, 0);
    w_mem_ready = 1'b0;
    w_s_valid = '0;
    rstn = 1'b1;
    w_s_data  = {32'h62, 32'h61, 32'h00};
    w_s_valid = 3'b110;
    tick();
    check("rst_ptr_grant", a_w_mem_data, 32'h61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
